mul_div_unit: RTL

Iterative 16-bit signed multiply/divide unit that sits in the execute stage, directly feeding the register file's write ports.
- Multiply: low product goes to the general write port (WA1/WD1/RegWrite); high product goes to the dedicated R0 port (R0D/R0W).
- Divide: quotient goes to the general write port; remainder goes to the R0 port.
- One operation in flight at a time. Fixed latency with a start/busy/done handshake.

---
 rtl/mul_div_unit_pkg.sv | 20 ++
 rtl/mul_div_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - state_e   : FSM state encoding (also exported on the debug port)
//   - OP_MUL/DIV: operation select values for the op input
//   - WIDTH_DEF : default operand/result width
package mul_div_unit_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Multiply: low product -> general write port, high product -> R0 port.
// Divide:   quotient    -> general write port, remainder    -> R0 port.
// Every operation takes 19 cycles from the accepting edge to the done pulse.
//
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-low reset
//   start, op        : request (sampled when busy=0), 0=mul 1=div
//   a, b, dest       : operands and destination register index
//   busy, done       : in progress / one-cycle completion pulse
//   wb_addr/data/en  : general register-file write port
//   r0_data/en       : dedicated R0 write port
//   div_zero         : sticky divide-by-zero flag, cleared on accepted start
//   dbg_state        : current FSM state
//
// Handshake: start is accepted on a rising edge where start=1 and busy=0
// (IDLE or DONE). Operands are captured on that edge; the inputs may change
// afterwards. done, wb_en and r0_en are high together for exactly one cycle,
// and the result registers hold until the next operation's FIX state.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       dest,
  output logic             busy,
  output logic             done,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_en,
  output logic [WIDTH-1:0] r0_data,
  output logic             r0_en,
  output logic             div_zero,
  output state_e           dbg_state
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               op_q;
  logic [3:0]         dest_q;
  logic               neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0]   opnd_q;          // |a| for mul, |b| for div
  logic [WIDTH-1:0]   hi_q, lo_q;      // shared 2*WIDTH shift register
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         wb_addr_q;
  logic [WIDTH-1:0]   wb_data_q, r0_data_q;
  logic               div_zero_q;

  logic               last_step;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH-1:0]   fix_lo, fix_hi;
  logic               fix_dz;

  // Two's-complement magnitude; 0x8000 maps to unsigned 0x8000.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = RUN;
      RUN:     if (last_step) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = start ? PREP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- iteration step ----------------
  // Mul: shift-add, multiplier in lo, partial product in hi (WIDTH+1 sum).
  // Div: restoring; remainder in hi, dividend shifts out of lo while the
  //      quotient bits shift in. Remainder < divisor <= 2^(WIDTH-1), so the
  //      WIDTH+1 bit trial value always fits back into WIDTH bits.
  always_comb begin
    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] shl_w;
    logic [WIDTH:0] diff_w;
    sum_w   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shl_w   = {hi_q, lo_q[WIDTH-1]};
    diff_w  = shl_w - {1'b0, opnd_q};
    step_hi = '0;
    step_lo = '0;
    if (op_q == OP_MUL) begin
      step_hi = sum_w[WIDTH:1];
      step_lo = {sum_w[0], lo_q[WIDTH-1:1]};
    end else if (shl_w >= {1'b0, opnd_q}) begin
      step_hi = diff_w[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = shl_w[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // ---------------- sign fix-up and divide special cases ----------------
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    prod   = {hi_q, lo_q};
    prod_s = neg_lo_q ? (~prod + 1'b1) : prod;
    fix_dz = 1'b0;
    fix_lo = '0;
    fix_hi = '0;
    if (op_q == OP_MUL) begin
      fix_lo = prod_s[WIDTH-1:0];
      fix_hi = prod_s[2*WIDTH-1:WIDTH];
    end else if (b_q == '0) begin
      fix_lo = '1;
      fix_hi = a_q;
      fix_dz = 1'b1;
    end else if (a_q == {1'b1, {(WIDTH-1){1'b0}}} && b_q == '1) begin
      fix_lo = {1'b1, {(WIDTH-1){1'b0}}};
      fix_hi = '0;
    end else begin
      fix_lo = neg_lo_q ? (~lo_q + 1'b1) : lo_q;
      fix_hi = neg_hi_q ? (~hi_q + 1'b1) : hi_q;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      dest_q     <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      r0_data_q  <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= op;
            dest_q     <= dest;
            div_zero_q <= 1'b0;
          end
        end
        PREP: begin
          neg_lo_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          neg_hi_q <= a_q[WIDTH-1];
          opnd_q   <= (op_q == OP_MUL) ? mag(a_q) : mag(b_q);
          lo_q     <= (op_q == OP_MUL) ? mag(b_q) : mag(a_q);
          hi_q     <= '0;
          cnt_q    <= '0;
        end
        RUN: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          if (!last_step) cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          wb_addr_q  <= dest_q;
          wb_data_q  <= fix_lo;
          r0_data_q  <= fix_hi;
          div_zero_q <= fix_dz;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
  assign done      = (state_q == DONE);
  assign wb_en     = done;
  assign r0_en     = done;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign r0_data   = r0_data_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule
